// File: rtl/serial_subtractor_if.sv
// Handshake/operand/result bundle for the bit-serial subtractor.
// Latency: none (wires only).
// Backpressure: none; start is only honoured by the slave when it is not busy.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  // Requester side: issues operands and start, observes status and results.
  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell and a registered borrow.
// Latency: start at edge E0 -> done high in the cycle after edge E_WIDTH; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; results hold until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  // A new operation is taken only when no operation is in flight.
  assign accept   = io.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    d_bit      = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    res_nxt    = {d_bit, res_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE lasts one cycle, or chains straight into a new operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = accept ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from state, so busy and done are exclusive.
  always_comb begin
    io.busy = (state_q == ST_SHIFT);
    io.done = (state_q == ST_DONE);
  end

  // Operand capture, serial shifting and result/flag update at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      sa_q     <= io.a;
      sb_q     <= io.b;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= io.a[WIDTH-1];
      b_msb_q  <= io.b[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
      res_q    <= res_nxt;
      borrow_q <= borrow_nxt;
      cnt_q    <= cnt_q + CW'(1);
      if (last_bit) begin
        diff_q <= res_nxt;
        bout_q <= borrow_nxt;
        zero_q <= (res_nxt == '0);
        // Overflow only possible when operand signs differ and the result sign flips away from a.
        ovf_q  <= (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf  = ovf_q;
  assign io.zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): results, flags, timing, hold, ignore and reset-abort.
// Inputs driven and outputs sampled on the falling edge.
// Back-to-back run uses an arithmetic reference for the random pairs.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ed, input logic eb,
                         input logic eo, input logic ez);
    chk({tag, ".diff"}, 32'(ifc.diff), 32'(ed));
    chk({tag, ".bout"}, 32'(ifc.bout), 32'(eb));
    chk({tag, ".ovf"},  32'(ifc.ovf),  32'(eo));
    chk({tag, ".zero"}, 32'(ifc.zero), 32'(ez));
  endtask

  // Waits (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(input string tag, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (ifc.done !== 1'b1 && n < 40) begin
      if (ifc.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".done"}, 32'(ifc.done), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(ifc.busy), 32'd0);
  endtask

  // Single start pulse; checks timing, hold of old result, new result and one-cycle done.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    logic [7:0] prev;
    int         bc;
    prev      = ifc.diff;
    ifc.a     = ta;
    ifc.b     = tbv;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    chk({tag, ".busy"}, 32'(ifc.busy), 32'd1);
    chk({tag, ".hold"}, 32'(ifc.diff), 32'(prev));
    wait_done(tag, bc);
    chk({tag, ".busy_cycles"}, 32'(bc), 32'd8);
    chk_out(tag, ed, eb, eo, ez);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(ifc.done), 32'd0);
    chk({tag, ".diff_after"}, 32'(ifc.diff), 32'(ed));
  endtask

  initial begin
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    logic [7:0] md;
    int         bc;
    int         seen;
    int         last_cyc;
    int         n;

    // Reset state
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(ifc.busy), 32'd0);
    chk("rst.done", 32'(ifc.done), 32'd0);
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, expected values worked by hand
    run_op("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0);
    run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("77-77", 8'h77, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("80-7F", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);

    // Start and operand change in the 3rd SHIFT cycle must be ignored
    ifc.a     = 8'h5A;
    ifc.b     = 8'h3C;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = 8'h11;
    ifc.b     = 8'h22;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a     = 8'h33;
    ifc.b     = 8'h44;
    wait_done("ign", bc);
    chk("ign.busy_cycles", 32'(bc), 32'd5);
    chk_out("ign", 8'h1E, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ign.idle", 32'(ifc.busy), 32'd0);

    // Reset in the 4th SHIFT cycle aborts the operation
    ifc.a     = 8'h12;
    ifc.b     = 8'h01;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(ifc.busy), 32'd0);
    chk("abort.done", 32'(ifc.done), 32'd0);
    chk_out("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ifc.done === 1'b1) seen++;
    end
    chk("abort.no_done", 32'(seen), 32'd0);
    run_op("post_rst", 8'h12, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high: corners plus 256 random pairs
    pa.push_back(8'h00); pb.push_back(8'hFF);
    pa.push_back(8'hFF); pb.push_back(8'h00);
    pa.push_back(8'h80); pb.push_back(8'h7F);
    for (int i = 0; i < 256; i++) begin
      pa.push_back(8'($urandom_range(255)));
      pb.push_back(8'($urandom_range(255)));
    end
    ifc.a     = pa[0];
    ifc.b     = pb[0];
    ifc.start = 1'b1;
    last_cyc  = 0;
    @(negedge clk);
    for (int i = 0; i < pa.size(); i++) begin
      n = 0;
      while (ifc.done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b.done", 32'(ifc.done), 32'd1);
      if (i > 0) chk("b2b.gap", 32'(cyc - last_cyc), 32'd9);
      last_cyc = cyc;
      md = pa[i] - pb[i];
      chk_out("b2b", md, pa[i] < pb[i],
              (pa[i][7] != pb[i][7]) && (md[7] != pa[i][7]), md == 8'h00);
      if (i + 1 < pa.size()) begin
        ifc.a = pa[i+1];
        ifc.b = pb[i+1];
      end else begin
        ifc.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b.end_done", 32'(ifc.done), 32'd0);
    chk("b2b.end_busy", 32'(ifc.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
